single_add_v_v_seq: RTL and testbench
=====================================

Name: single_add_v_v_seq

Overview:
- Initiator side of the vector-adder start/done handshake.
- Accepts operand pairs one element per cycle on a valid/ready stream and assembles them into WIDTH-element vectors.
- Pulses start to a parallel single-precision vector adder, captures the result on done, and streams the result back out one element per cycle.
- Bridges serial datapaths (memory, DMA) to the parallel vector arithmetic blocks.

Parameters:
- WIDTH, 10, number of 32-bit elements per vector; must be >= 2.
- TIMEOUT, 64, cycles allowed in WAIT before the watchdog fires; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  32  operand A element, IEEE-754 single.
- in_b  input  32  operand B element, IEEE-754 single.
- out_valid  output  1  result element valid.
- out_ready  input  1  downstream accepts the result element.
- out_c  output  32  result element.
- out_last  output  1  marks element WIDTH-1 of the result stream.
- busy  output  1  high in every state except LOAD.
- error  output  1  sticky watchdog flag.
- start  output  1  one-cycle pulse to the adder.
- done  input  1  adder completion.
- vector_a  output  [31:0] x WIDTH  operand A vector to the adder.
- vector_b  output  [31:0] x WIDTH  operand B vector to the adder.
- vector_c  input  [31:0] x WIDTH  result vector from the adder.

Behaviour:
- Reset (asynchronous assert):
  - State goes to LOAD; index and watchdog counters go to 0.
  - All vector_a, vector_b and result registers go to 0.
  - start, out_valid, out_last, busy and error go to 0.
  - out_c goes to 0 and in_ready goes to 1.
  - Reset mid-operation abandons the vector; no partial output is produced afterwards.
- LOAD state:
  - in_ready=1.
  - On each in_valid && in_ready, write in_a into vector_a[idx] and in_b into vector_b[idx], then idx++.
  - Gaps in in_valid are allowed; state is held.
  - On the handshake with idx==WIDTH-1: set idx to 0 and go to START.
- START state:
  - start=1 for exactly one cycle, in the cycle after the final accept.
  - in_ready=0; next state is WAIT.
- WAIT state:
  - in_ready=0; done is sampled.
  - On done=1: capture vector_c into the result registers and go to DRAIN.
- vector_a and vector_b are written only in LOAD, so they are stable from START through WAIT.
- DRAIN state:
  - out_valid=1, out_c=result[idx], out_last=(idx==WIDTH-1).
  - On out_valid && out_ready: idx++.
  - On the handshake with out_last: set idx to 0 and go to LOAD.
  - While out_ready=0, out_c and out_last are held stable.
- done is ignored in LOAD, START and DRAIN. A spurious done has no effect.
- There are no back-to-back overlaps: the next LOAD begins the cycle after the last output handshake.
- Minimum round trip = WIDTH load cycles + 1 START + adder latency + WIDTH drain cycles.
- All outputs are registered, except in_ready and out_valid, which decode directly from state.
- No arithmetic on data: elements pass through bit-exact.
- Counter width is clog2(WIDTH).

Optional Feature:
- Macro: SINGLE_ADD_V_V_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT, cleared on entry to WAIT.
  - If TIMEOUT cycles elapse without done, set error=1 (sticky until rst), discard the vector and return to LOAD with idx=0.
  - done in the same cycle as expiry wins: capture the result and go to DRAIN.
- Not defined:
  - No watchdog logic; WAIT persists until done.
  - error is tied to 0; TIMEOUT is unused.

Test Plan:
- Basic add, WIDTH=4:
  - Stimulus: a={0x3F800000,0x40000000,0x40400000,0x40800000}, b=4x0x3F800000, stub adder with 1-cycle done.
  - Response: start pulses one cycle after the 4th accept; out_c sequence 0x40000000,0x40400000,0x40800000,0x40A00000; out_last only on the 4th; busy falls the cycle after it.
- Input gaps and output backpressure:
  - Stimulus: in_valid toggles 1,0,1,0; out_ready held 0 for 5 cycles, then toggling.
  - Response: identical output values; out_c and out_last stable while out_ready=0; no element lost or duplicated.
- Spurious done:
  - Stimulus: pulse done during LOAD after 2 elements, and again during DRAIN.
  - Response: idx unchanged; no state change; output sequence unchanged.
- Reset mid-DRAIN:
  - Stimulus: assert rst after 2 of 4 outputs.
  - Response: outputs go to 0 immediately (async); after release in_ready=1 and busy=0; the next full vector produces correct results from element 0.
- Watchdog (macro defined, TIMEOUT=8):
  - Stimulus: stub never asserts done.
  - Response: error=1 eight cycles after entering WAIT; in_ready=1 next cycle; no out_valid; error stays 1 through a subsequent good vector until rst.
- Watchdog race:
  - Stimulus: done asserted exactly on the expiry cycle.
  - Response: result captured, DRAIN entered, error stays 0.

Source files
------------

// File: rtl/single_add_v_v_seq.sv
// Serial-to-parallel sequencer that drives a vector adder over a start/done handshake.
// SINGLE_ADD_V_V_SEQ_TIMEOUT_EN adds a sticky WAIT watchdog that reports on error.
module single_add_v_v_seq #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_c,
  output logic                  out_last,
  output logic                  busy,
  output logic                  error,
  output logic                  start,
  input  logic                  done,
  output logic [WIDTH*32-1:0]   vector_a,
  output logic [WIDTH*32-1:0]   vector_b,
  input  logic [WIDTH*32-1:0]   vector_c
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   va_q  [WIDTH];
  logic [31:0]   vb_q  [WIDTH];
  logic [31:0]   res_q [WIDTH];
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;
  logic [31:0]   out_c_q, out_c_d;
  logic          load_en, cap_en;
  logic          in_hs, out_hs;

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          expired;

  assign expired = (wd_q == TW'(TIMEOUT - 1));
  assign error   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      out_c_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      out_c_q <= out_c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_en = 1'b0;
    cap_en  = 1'b0;
`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (in_hs) begin
          load_en = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        // done beats a simultaneous watchdog expiry
        if (done) begin
          cap_en  = 1'b1;
          state_d = S_DRAIN;
        end
`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
        else if (expired) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    start_d   = (state_d == S_START);
    busy_d    = (state_d != S_LOAD);
    last_d    = (state_d == S_DRAIN) && (idx_d == LAST);
    out_c_d   = '0;
    if (state_d == S_DRAIN) begin
      out_c_d = cap_en ? vector_c[31:0] : res_q[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        va_q[i]  <= '0;
        vb_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      if (load_en) begin
        va_q[idx_q] <= in_a;
        vb_q[idx_q] <= in_b;
      end
      if (cap_en) begin
        for (int i = 0; i < WIDTH; i++) begin
          res_q[i] <= vector_c[i*32 +: 32];
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_vec
    assign vector_a[g*32 +: 32] = va_q[g];
    assign vector_b[g*32 +: 32] = vb_q[g];
  end

  assign start    = start_q;
  assign busy     = busy_q;
  assign out_last = last_q;
  assign out_c    = out_c_q;

endmodule

// File: tb/tb_single_add_v_v_seq.sv
// Bench for single_add_v_v_seq: stub adder, transaction model, directed vectors.
// Watchdog scenarios run when SINGLE_ADD_V_V_SEQ_TIMEOUT_EN is defined.
module tb_single_add_v_v_seq;
  localparam int W = 4;
`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_c;
  logic out_last, busy, error, start, done;
  logic [W*32-1:0] vector_a, vector_b, vector_c;
  logic stub_done, spur_done;
  bit stub_en, stub_pend;

  int errors = 0;
  int checks = 0;

  single_add_v_v_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_last(out_last),
    .busy(busy), .error(error),
    .start(start), .done(done),
    .vector_a(vector_a), .vector_b(vector_b),
    .vector_c(vector_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign done = stub_done | spur_done;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  // stub adder: done one cycle after it sees start
  initial begin
    stub_done = 1'b0;
    stub_pend = 1'b0;
    vector_c  = '0;
    forever begin
      @(posedge clk);
      #1;
      stub_done = 1'b0;
      if (rst) begin
        stub_pend = 1'b0;
      end else if (stub_pend) begin
        stub_done = 1'b1;
        for (int i = 0; i < W; i++)
          vector_c[i*32 +: 32] = fadd(vector_a[i*32 +: 32],
                                      vector_b[i*32 +: 32]);
        stub_pend = 1'b0;
      end else if (start && stub_en) begin
        stub_pend = 1'b1;
      end
    end
  end

  // transaction model, evaluated mid-cycle for the coming edge
  bit m_busy, m_start, m_wait, m_drain, m_err;
  int m_pos, m_wcnt;
  logic [31:0] qa[$], qb[$], expv[$], obs[$];

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_start = 0; m_wait = 0;
      m_drain = 0; m_err = 0; m_pos = 0; m_wcnt = 0;
      qa.delete(); qb.delete(); expv.delete(); obs.delete();
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("start", {31'd0, start}, {31'd0, m_start});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_drain});
      chk("error", {31'd0, error}, {31'd0, m_err});
      if (m_drain) begin
        chk("out_c", out_c, expv[m_pos]);
        chk("out_last", {31'd0, out_last}, {31'd0, m_pos == W - 1});
      end
      if (!m_busy) begin
        if (in_valid) begin
          qa.push_back(in_a);
          qb.push_back(in_b);
          if (qa.size() == W) begin
            expv.delete();
            for (int i = 0; i < W; i++) expv.push_back(fadd(qa[i], qb[i]));
            qa.delete(); qb.delete();
            m_busy = 1; m_start = 1;
          end
        end
      end else if (m_start) begin
        m_start = 0; m_wait = 1; m_wcnt = 0;
      end else if (m_wait) begin
        if (done) begin
          m_wait = 0; m_drain = 1; m_pos = 0;
        end
`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_wait = 0; m_busy = 0; m_err = 1;
          end
        end
`endif
      end else if (m_drain && out_ready) begin
        obs.push_back(out_c);
        m_pos++;
        if (m_pos == W) begin
          m_drain = 0; m_busy = 0;
        end
      end
    end
  end

  task automatic send(input logic [W*32-1:0] av, input logic [W*32-1:0] bv,
                      input int gap, input bit spur);
    int n;
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1;
      in_a = av[i*32 +: 32];
      in_b = bv[i*32 +: 32];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        errors++;
        $display("FAIL send_timeout: got %0d expected <100", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (spur && i == 1) begin
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
      end
      if (i < W - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input int spur_at);
    int n = 0;
    while (m_busy && n < 300) begin
      @(posedge clk);
      #1;
      spur_done = (n == spur_at) && out_valid;
      n++;
    end
    spur_done = 1'b0;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL idle_timeout: got %0d cycles expected <300", n);
    end
  endtask

  task automatic chk_obs(input string nm, input logic [W*32-1:0] ev);
    chk({nm, "_count"}, obs.size(), W);
    for (int i = 0; i < W && i < obs.size(); i++)
      chk(nm, obs[i], ev[i*32 +: 32]);
  endtask

  logic [W*32-1:0] a1, b1, c1, a2, b2, c2;
  int n;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    a1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    b1 = {4{32'h3F800000}};
    c1 = {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000};
    a2 = {32'h00000000, 32'hBF800000, 32'h40A00000, 32'h41200000};
    b2 = {32'h40000000, 32'h3F800000, 32'h40A00000, 32'h3F800000};
    c2 = {32'h40000000, 32'h00000000, 32'h41200000, 32'h41300000};
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; spur_done = 1'b0; stub_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_c", out_c, 32'd0);
    chk("rst_vector_a", vector_a[31:0], 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(a1, b1, 0, 1'b0);
    wait_idle(-1);
    chk_obs("basic", c1);
    obs.delete();

    out_ready = 1'b0;
    send(a2, b2, 1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    n = 0;
    while (m_busy && n < 100) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    chk_obs("backpressure", c2);
    obs.delete();

    send(a1, b1, 0, 1'b1);
    wait_idle(2);
    chk_obs("spurious", c1);
    obs.delete();

    send(a2, b2, 0, 1'b0);
    n = 0;
    while (!(m_drain && m_pos == 2) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_c", out_c, 32'd0);
    chk("arst_out_last", {31'd0, out_last}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    obs.delete();
    send(a1, b1, 0, 1'b0);
    wait_idle(-1);
    chk_obs("after_reset", c1);
    obs.delete();

`ifdef SINGLE_ADD_V_V_SEQ_TIMEOUT_EN
    stub_en = 1'b0;
    send(a1, b1, 0, 1'b0);
    n = 0;
    while (!error && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wd_error", {31'd0, error}, 32'd1);
    chk("wd_no_output", obs.size(), 0);
    stub_en = 1'b1;
    send(a2, b2, 0, 1'b0);
    wait_idle(-1);
    chk_obs("wd_next", c2);
    chk("wd_sticky", {31'd0, error}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs.delete();
    stub_en = 1'b0;
    send(a1, b1, 0, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    wait_idle(-1);
    chk_obs("wd_race", c1);
    chk("wd_race_error", {31'd0, error}, 32'd0);
    stub_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
